// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hazard_ctrl_unit                                           |
// | Description : 5-stage pipeline hazard control: N-operand forwarding,     |
// |               load-use stall, branch flush, long-latency E-stage FSM and |
// |               a saturating stall-cycle counter.                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module hazard_ctrl_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int LONG_LAT   = 4,
    parameter int CNT_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_d,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_e,
    input  logic [REG_ADDR_W-1:0]         rd_e,
    input  logic                          mem_read_e,
    input  logic                          long_op_e,
    input  logic                          pc_src_e,
    input  logic [REG_ADDR_W-1:0]         rd_m,
    input  logic [REG_ADDR_W-1:0]         rd_w,
    input  logic                          reg_write_m,
    input  logic                          reg_write_w,
    output logic [2*NUM_SRC-1:0]          forward_e,
    output logic                          stall_f,
    output logic                          stall_d,
    output logic                          stall_e,
    output logic                          flush_d,
    output logic                          flush_e,
    output logic                          flush_m,
    output logic                          long_busy,
    input  logic                          cnt_clr,
    output logic [CNT_W-1:0]              stall_cnt
);

    localparam int         c_REM_W    = $clog2(LONG_LAT) + 1;
    localparam int         c_REM_INIT = (LONG_LAT > 1) ? (LONG_LAT - 2) : 0;
    localparam logic       c_LONG_EN  = (LONG_LAT > 1);
    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_BUSY     = 2'd1;
    localparam logic [1:0] c_DONE     = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_REM_W-1:0] r_rem;
    logic [c_REM_W-1:0] w_rem_nxt;
    logic [NUM_SRC-1:0] w_lw_match;
    logic               w_lw_hit;
    logic               w_long_stall;
    logic [CNT_W-1:0]   r_cnt;

    // Memory-stage result is newer than writeback, so it wins; x0 never forwards.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_fwd
        logic [REG_ADDR_W-1:0] w_src;
        logic                  w_hit_m;
        logic                  w_hit_w;
        assign w_src   = rs_e[gi*REG_ADDR_W +: REG_ADDR_W];
        assign w_hit_m = reg_write_m && (rd_m != '0) && (rd_m == w_src);
        assign w_hit_w = reg_write_w && (rd_w != '0) && (rd_w == w_src);
        assign forward_e[2*gi +: 2] = w_hit_m ? 2'b10 : (w_hit_w ? 2'b01 : 2'b00);
    end

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_lw
        assign w_lw_match[gi] = (rd_e == rs_d[gi*REG_ADDR_W +: REG_ADDR_W]);
    end

    assign w_lw_hit     = mem_read_e && (rd_e != '0) && (|w_lw_match);
    assign w_long_stall = ((r_state == c_IDLE) && long_op_e && c_LONG_EN) ||
                          (r_state == c_BUSY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    // rem counts the BUSY cycles still to go before the op reaches DONE.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        case (r_state)
            c_IDLE: begin
                if (long_op_e && c_LONG_EN) begin
                    w_rem_nxt   = c_REM_W'(c_REM_INIT);
                    w_state_nxt = (LONG_LAT == 2) ? c_DONE : c_BUSY;
                end
            end
            c_BUSY: begin
                if (r_rem == c_REM_W'(1)) begin
                    w_state_nxt = c_DONE;
                end else begin
                    w_rem_nxt = r_rem - c_REM_W'(1);
                end
            end
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // A taken branch drops a pending load-use stall: D holds a wrong-path instr.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        if (!rst) begin
            if (w_long_stall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                flush_m = 1'b1;
            end else if (pc_src_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (w_lw_hit) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    assign long_busy = !rst && (r_state != c_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (stall_d && !(&r_cnt)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_hazard_ctrl_unit                                        |
// | Description : Directed scoreboard bench; three DUTs with LONG_LAT 4/1/2  |
// |               share one stimulus stream.                                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_hazard_ctrl_unit;

    // ctl word layout: {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, long_busy}
    localparam logic [6:0] c_NONE  = 7'b000_000_0;
    localparam logic [6:0] c_LW    = 7'b110_010_0;
    localparam logic [6:0] c_BR    = 7'b000_110_0;
    localparam logic [6:0] c_BRB   = 7'b000_110_1;
    localparam logic [6:0] c_LONG  = 7'b111_001_0;
    localparam logic [6:0] c_LONGB = 7'b111_001_1;
    localparam logic [6:0] c_DONE  = 7'b000_000_1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] rs_d, rs_e;
    logic [4:0] rd_e, rd_m, rd_w;
    logic       mem_read_e, long_op_e, pc_src_e, reg_write_m, reg_write_w, cnt_clr;

    logic [3:0] fwd [3];
    logic [6:0] ctl [3];
    logic [3:0] cnt [3];

    typedef struct {
        string            name;
        logic [3:0]       fwd;
        logic [2:0][6:0]  ctl;
        logic [2:0][3:0]  cnt;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    for (genvar gk = 0; gk < 3; gk++) begin : g_dut
        localparam int c_LAT = (gk == 0) ? 4 : ((gk == 1) ? 1 : 2);
        logic sf, sd, se, fd, fe, fm, lb;
        hazard_ctrl_unit #(
            .REG_ADDR_W(5), .NUM_SRC(2), .LONG_LAT(c_LAT), .CNT_W(4)
        ) u_dut (
            .clk(clk), .rst(rst), .rs_d(rs_d), .rs_e(rs_e), .rd_e(rd_e),
            .mem_read_e(mem_read_e), .long_op_e(long_op_e), .pc_src_e(pc_src_e),
            .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
            .forward_e(fwd[gk]), .stall_f(sf), .stall_d(sd), .stall_e(se),
            .flush_d(fd), .flush_e(fe), .flush_m(fm), .long_busy(lb),
            .cnt_clr(cnt_clr), .stall_cnt(cnt[gk])
        );
        assign ctl[gk] = {sf, sd, se, fd, fe, fm, lb};
    end

    // Monitor: combinational outputs are presented every cycle; check mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            total++;
            if (fwd[0] !== e.fwd) begin
                bad++;
                $display("FAIL %s fwd: got %b want %b", e.name, fwd[0], e.fwd);
            end
            for (int k = 0; k < 3; k++) begin
                total++;
                if (ctl[k] !== e.ctl[k]) begin
                    bad++;
                    $display("FAIL %s ctl[dut%0d]: got %b want %b", e.name, k, ctl[k], e.ctl[k]);
                end
                total++;
                if (cnt[k] !== e.cnt[k]) begin
                    bad++;
                    $display("FAIL %s cnt[dut%0d]: got %0d want %0d", e.name, k, cnt[k], e.cnt[k]);
                end
            end
        end
    end

    // Index order of expectations: 0 = LONG_LAT 4, 1 = LONG_LAT 1, 2 = LONG_LAT 2.
    task automatic expect_out(input string nm, input logic [3:0] f,
                              input logic [6:0] a0, input logic [6:0] a1, input logic [6:0] a2,
                              input logic [3:0] n0, input logic [3:0] n1, input logic [3:0] n2);
        exp_t e;
        e.name = nm;
        e.fwd  = f;
        e.ctl  = {a2, a1, a0};
        e.cnt  = {n2, n1, n0};
        q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        rs_d = '0; rs_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
        mem_read_e = 1'b0; long_op_e = 1'b0; pc_src_e = 1'b0;
        reg_write_m = 1'b0; reg_write_w = 1'b0; cnt_clr = 1'b0;
    endtask

    initial begin
        clear_in();
        // Reset masks every stall/flush even with hazards on the inputs.
        next_cycle();
        mem_read_e = 1'b1; rd_e = 5'd7; rs_d = {5'd7, 5'd0}; long_op_e = 1'b1;
        expect_out("rst_mask", 4'b0000, c_NONE, c_NONE, c_NONE, 0, 0, 0);
        next_cycle();
        rst = 1'b0; clear_in();
        expect_out("post_rst", 4'b0000, c_NONE, c_NONE, c_NONE, 0, 0, 0);

        // Forwarding
        next_cycle();
        rs_e = {5'd5, 5'd5}; rd_m = 5'd5; reg_write_m = 1'b1; rd_w = 5'd5; reg_write_w = 1'b1;
        expect_out("fwd_m_prio", 4'b1010, c_NONE, c_NONE, c_NONE, 0, 0, 0);
        next_cycle();
        reg_write_m = 1'b0;
        expect_out("fwd_w", 4'b0101, c_NONE, c_NONE, c_NONE, 0, 0, 0);
        next_cycle();
        rd_m = 5'd0; rd_w = 5'd0; reg_write_m = 1'b1;
        expect_out("fwd_none", 4'b0000, c_NONE, c_NONE, c_NONE, 0, 0, 0);
        next_cycle();
        rs_e = {5'd3, 5'd9}; rd_m = 5'd9; rd_w = 5'd3;
        expect_out("fwd_mixed", 4'b0110, c_NONE, c_NONE, c_NONE, 0, 0, 0);
        next_cycle();
        rs_e = '0; rd_m = 5'd0; rd_w = 5'd0;
        expect_out("fwd_x0", 4'b0000, c_NONE, c_NONE, c_NONE, 0, 0, 0);

        // Load-use
        next_cycle();
        clear_in(); mem_read_e = 1'b1; rd_e = 5'd7; rs_d = {5'd7, 5'd2};
        expect_out("lw_op1", 4'b0000, c_LW, c_LW, c_LW, 0, 0, 0);
        next_cycle();
        clear_in();
        expect_out("lw_after", 4'b0000, c_NONE, c_NONE, c_NONE, 1, 1, 1);
        next_cycle();
        mem_read_e = 1'b1; rd_e = 5'd0; rs_d = {5'd0, 5'd0};
        expect_out("lw_rd0", 4'b0000, c_NONE, c_NONE, c_NONE, 1, 1, 1);
        next_cycle();
        rd_e = 5'd12; rs_d = {5'd4, 5'd12};
        expect_out("lw_op0", 4'b0000, c_LW, c_LW, c_LW, 1, 1, 1);
        next_cycle();
        mem_read_e = 1'b0;
        expect_out("lw_noload", 4'b0000, c_NONE, c_NONE, c_NONE, 2, 2, 2);

        // Branch beats load-use
        next_cycle();
        mem_read_e = 1'b1; rd_e = 5'd7; rs_d = {5'd7, 5'd2}; pc_src_e = 1'b1;
        expect_out("br_vs_lw", 4'b0000, c_BR, c_BR, c_BR, 2, 2, 2);
        next_cycle();
        clear_in();
        expect_out("br_after", 4'b0000, c_NONE, c_NONE, c_NONE, 2, 2, 2);

        // Long op held for five cycles
        next_cycle();
        long_op_e = 1'b1;
        expect_out("long_c0", 4'b0000, c_LONG, c_NONE, c_LONG, 2, 2, 2);
        next_cycle();
        expect_out("long_c1", 4'b0000, c_LONGB, c_NONE, c_DONE, 3, 2, 3);
        next_cycle();
        expect_out("long_c2", 4'b0000, c_LONGB, c_NONE, c_LONG, 4, 2, 3);
        next_cycle();
        expect_out("long_c3", 4'b0000, c_DONE, c_NONE, c_DONE, 5, 2, 4);
        next_cycle();
        expect_out("long_c4", 4'b0000, c_LONG, c_NONE, c_LONG, 5, 2, 4);
        next_cycle();
        long_op_e = 1'b0;
        expect_out("long_c5", 4'b0000, c_LONGB, c_NONE, c_DONE, 6, 2, 5);

        // Reset in the middle of BUSY
        next_cycle();
        rst = 1'b1;
        expect_out("rst_midop", 4'b0000, c_NONE, c_NONE, c_NONE, 0, 0, 0);
        next_cycle();
        rst = 1'b0;
        expect_out("rst_noresid", 4'b0000, c_NONE, c_NONE, c_NONE, 0, 0, 0);

        // Long stall masks branch and load-use
        next_cycle();
        long_op_e = 1'b1;
        expect_out("mask_c0", 4'b0000, c_LONG, c_NONE, c_LONG, 0, 0, 0);
        next_cycle();
        long_op_e = 1'b0; pc_src_e = 1'b1; mem_read_e = 1'b1; rd_e = 5'd7; rs_d = {5'd7, 5'd2};
        expect_out("mask_br", 4'b0000, c_LONGB, c_BR, c_BRB, 1, 0, 1);
        next_cycle();
        pc_src_e = 1'b0;
        expect_out("mask_lw", 4'b0000, c_LONGB, c_LW, c_LW, 2, 0, 1);
        next_cycle();
        clear_in();
        expect_out("mask_done", 4'b0000, c_DONE, c_NONE, c_NONE, 3, 1, 2);
        next_cycle();
        expect_out("mask_idle", 4'b0000, c_NONE, c_NONE, c_NONE, 3, 1, 2);

        // Counter clear, saturation, clear-over-increment
        next_cycle();
        cnt_clr = 1'b1;
        expect_out("cnt_clr", 4'b0000, c_NONE, c_NONE, c_NONE, 3, 1, 2);
        for (int j = 0; j < 20; j++) begin
            next_cycle();
            cnt_clr = 1'b0; mem_read_e = 1'b1; rd_e = 5'd7; rs_d = {5'd7, 5'd2};
            expect_out($sformatf("sat_%0d", j), 4'b0000, c_LW, c_LW, c_LW,
                       4'((j > 15) ? 15 : j), 4'((j > 15) ? 15 : j), 4'((j > 15) ? 15 : j));
        end
        next_cycle();
        cnt_clr = 1'b1;
        expect_out("sat_full", 4'b0000, c_LW, c_LW, c_LW, 15, 15, 15);
        next_cycle();
        clear_in();
        expect_out("clr_prio", 4'b0000, c_NONE, c_NONE, c_NONE, 0, 0, 0);

        for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clk);
        @(posedge clk);
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
